imm_gen_pipe: RTL

//  Pipelined, parametrised immediate generator for the decode stage. Accepts raw instructions on a

---
 rtl/imm_gen_pipe.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator for the decode stage.
// Decodes I/S/B/U/J/shift-immediate formats from a raw instruction, then
// buffers the result in a 2-entry skid FIFO. Throughput is one per cycle and
// in_ready comes from a flop, so ready has no combinational path.
//
// Parameters: XLEN (32 or 64) immediate width, ILEN (must be 32) instr width.
// Ports:
//   clock, reset (async, active-high), flush (sync discard of all entries)
//   in_valid/in_ready/in_instr    : instruction input handshake
//   out_valid/out_ready           : result output handshake
//   out_imm [XLEN], out_fmt [3]   : head entry (0 NONE 1 I 2 S 3 B 4 U 5 J 6 SHAMT)
//   out_illegal                   : unrecognised opcode / bad shamt
// Build option: define IMM_GEN_ILLEGAL_FLAG_EN to store and report out_illegal;
// otherwise out_illegal is tied low and no per-entry flag storage exists.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned FMTW = 3;

  localparam logic [FMTW-1:0] FMT_NONE  = 3'd0;
  localparam logic [FMTW-1:0] FMT_I     = 3'd1;
  localparam logic [FMTW-1:0] FMT_S     = 3'd2;
  localparam logic [FMTW-1:0] FMT_B     = 3'd3;
  localparam logic [FMTW-1:0] FMT_U     = 3'd4;
  localparam logic [FMTW-1:0] FMT_J     = 3'd5;
  localparam logic [FMTW-1:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Elaboration-time parameter legality checks
  if (ILEN != 32) begin : g_bad_ilen
    $error("imm_gen_pipe: ILEN must be 32");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic [XLEN-1:0]   dec_imm;
  logic [FMTW-1:0]   dec_fmt;
  logic [XLEN-1:0]   mem_imm [2];
  logic [FMTW-1:0]   mem_fmt [2];
  logic              rd_ptr, wr_ptr, rd_ptr_n;
  logic              push, pop, head_from_in;
  logic [XLEN-1:0]   head_imm_n;
  logic [FMTW-1:0]   head_fmt_n;
  logic [6:0]        opcode;
  logic [2:0]        funct3;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Immediate decode; unknown opcodes yield a clean zero / NONE
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    unique case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_imm = XLEN'($signed(in_instr[31:20]));
        dec_fmt = FMT_I;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (XLEN == 32) dec_imm = XLEN'(in_instr[24:20]);
          else            dec_imm = XLEN'(in_instr[25:20]);
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_imm = XLEN'($signed(in_instr[31:20]));
          dec_fmt = FMT_I;
        end
      end
      OP_STORE: begin
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
        dec_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
        dec_fmt = FMT_J;
      end
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next head: the entry rd_ptr will point at after this cycle; it is the
  // incoming beat when that beat lands in the head slot.
  assign rd_ptr_n     = rd_ptr ^ pop;
  assign head_from_in = push && (wr_ptr == rd_ptr_n);
  assign head_imm_n   = head_from_in ? dec_imm : mem_imm[rd_ptr_n];
  assign head_fmt_n   = head_from_in ? dec_fmt : mem_fmt[rd_ptr_n];

  // Skid FIFO state, storage and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= FMT_NONE;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_fmt[i] <= FMT_NONE;
      end
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= FMT_NONE;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_fmt[wr_ptr] <= dec_fmt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      out_imm <= head_imm_n;
      out_fmt <= head_fmt_n;
      case (state)
        EMPTY: if (push) begin
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (push && !pop) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop && !push) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: if (pop) begin
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMM_GEN_ILLEGAL_FLAG_EN
  logic dec_ill;
  logic mem_ill [2];

  // Unknown opcode, or shamt[5] set on a 32-bit datapath (immediate still produced)
  assign dec_ill = (dec_fmt == FMT_NONE) ||
                   ((dec_fmt == FMT_SHAMT) && (XLEN == 32) && in_instr[25]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_illegal <= 1'b0;
      mem_ill[0]  <= 1'b0;
      mem_ill[1]  <= 1'b0;
    end else if (flush) begin
      out_illegal <= 1'b0;
    end else begin
      if (push) mem_ill[wr_ptr] <= dec_ill;
      out_illegal <= head_from_in ? dec_ill : mem_ill[rd_ptr_n];
    end
  end
`else
  assign out_illegal = 1'b0;
`endif

endmodule
